// File: rtl/i2c_cond_pkg.sv
// Shared types for the I2C START/RESTART/STOP condition generator.
package i2c_cond_pkg;

    localparam int CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        OP_START   = 2'd0,
        OP_RESTART = 2'd1,
        OP_STOP    = 2'd2,
        OP_RSVD    = 2'd3
    } op_e;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_BUS_FREE   = 4'd1,
        ST_STA_HOLD   = 4'd2,
        ST_RS_SDA_REL = 4'd3,
        ST_RS_SCL_REL = 4'd4,
        ST_RS_SETUP   = 4'd5,
        ST_SP_SDA_LOW = 4'd6,
        ST_SP_SCL_REL = 4'd7,
        ST_SP_SETUP   = 4'd8,
        ST_SP_BUF     = 4'd9
    } state_e;

endpackage

// File: rtl/i2c_phase_timer.sv
// Loadable down-counter that holds at zero; load wins over decrement.
// Latency 1 cycle from load/dec to the zero flag; no backpressure.
module i2c_phase_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/i2c_condition_generator.sv
// START / repeated START / STOP sequencer on open-drain SCL/SDA with tBUF, stretch timeout and arbitration checks.
// Commands accepted only in IDLE (cmd_ready); outputs decoded from registered state, pulses land on the first IDLE cycle.
module i2c_condition_generator
    import i2c_cond_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    input  logic [1:0]       cmd_op,
    output logic             cmd_ready,
    input  logic [CNT_W-1:0] cfg_t_buf,
    input  logic [CNT_W-1:0] cfg_t_hd_sta,
    input  logic [CNT_W-1:0] cfg_t_su_sta,
    input  logic [CNT_W-1:0] cfg_t_su_sto,
    input  logic [CNT_W-1:0] cfg_t_stretch,
    input  logic             scl_in,
    input  logic             sda_in,
    output logic             scl_oe,
    output logic             sda_oe,
    output logic             owned,
    output logic             done,
    output logic             arb_lost,
    output logic             stretch_to,
    output logic             cmd_err
);

    state_e state_q, state_d;
    logic owned_q, owned_d;
    logic done_q, done_d;
    logic arb_q, arb_d;
    logic sto_q, sto_d;
    logic err_q, err_d;
    logic str_en_q, str_en_d;

    logic             p_load, p_dec, p_zero;
    logic [CNT_W-1:0] p_val;
    logic             s_load, s_dec, s_zero;
    logic [CNT_W-1:0] s_val;
    logic             in_wait, arb_hit, str_hit;

    i2c_phase_timer #(.W(CNT_W)) u_phase (
        .clk(clk), .reset(reset), .load(p_load), .load_val(p_val), .dec(p_dec), .zero(p_zero)
    );

    // Loaded with cfg-1 so the zero flag marks the cfg_t_stretch-th low cycle.
    assign s_val = cfg_t_stretch - 1'b1;

    i2c_phase_timer #(.W(CNT_W)) u_stretch (
        .clk(clk), .reset(reset), .load(s_load), .load_val(s_val), .dec(s_dec), .zero(s_zero)
    );

    always_comb begin
        scl_oe = 1'b0;
        sda_oe = 1'b0;
        case (state_q)
            ST_IDLE:       begin scl_oe = owned_q; sda_oe = owned_q; end
            ST_STA_HOLD:   sda_oe = 1'b1;
            ST_RS_SDA_REL: scl_oe = 1'b1;
            ST_SP_SDA_LOW: begin scl_oe = 1'b1; sda_oe = 1'b1; end
            ST_SP_SCL_REL,
            ST_SP_SETUP:   sda_oe = 1'b1;
            default:       ;
        endcase
    end

    // STA_HOLD drives SDA itself, so only the released-SDA phases can lose arbitration.
    assign arb_hit = ((state_q == ST_RS_SETUP) || (state_q == ST_SP_BUF)) &&
                     !sda_oe && scl_in && !sda_in;
    assign in_wait = (state_q == ST_RS_SCL_REL) || (state_q == ST_SP_SCL_REL);
    assign str_hit = in_wait && !scl_in && str_en_q && s_zero;

    always_comb begin
        state_d  = state_q;
        owned_d  = owned_q;
        str_en_d = str_en_q;
        done_d   = 1'b0;
        arb_d    = 1'b0;
        sto_d    = 1'b0;
        err_d    = 1'b0;
        p_load   = 1'b0;
        p_val    = '0;
        p_dec    = 1'b0;
        s_load   = 1'b0;
        s_dec    = 1'b0;
        if (arb_hit) begin
            state_d = ST_IDLE;
            owned_d = 1'b0;
            arb_d   = 1'b1;
        end else if (str_hit) begin
            state_d = ST_IDLE;
            owned_d = 1'b0;
            sto_d   = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        case (op_e'(cmd_op))
                            OP_START:   if (!owned_q) begin
                                            state_d = ST_BUS_FREE; p_load = 1'b1; p_val = cfg_t_buf;
                                        end else err_d = 1'b1;
                            OP_RESTART: if (owned_q) begin
                                            state_d = ST_RS_SDA_REL; p_load = 1'b1; p_val = cfg_t_hd_sta;
                                        end else err_d = 1'b1;
                            OP_STOP:    if (owned_q) begin
                                            state_d = ST_SP_SDA_LOW; p_load = 1'b1; p_val = cfg_t_hd_sta;
                                        end else err_d = 1'b1;
                            default:    err_d = 1'b1;
                        endcase
                    end
                end
                ST_BUS_FREE: begin
                    if (!scl_in || !sda_in) begin
                        p_load = 1'b1; p_val = cfg_t_buf;
                    end else if (p_zero) begin
                        state_d = ST_STA_HOLD; p_load = 1'b1; p_val = cfg_t_hd_sta;
                    end else p_dec = 1'b1;
                end
                ST_STA_HOLD: begin
                    if (p_zero) begin
                        state_d = ST_IDLE; owned_d = 1'b1; done_d = 1'b1;
                    end else p_dec = 1'b1;
                end
                ST_RS_SDA_REL, ST_SP_SDA_LOW: begin
                    if (p_zero) begin
                        state_d  = (state_q == ST_RS_SDA_REL) ? ST_RS_SCL_REL : ST_SP_SCL_REL;
                        s_load   = 1'b1;
                        str_en_d = (cfg_t_stretch != '0);
                    end else p_dec = 1'b1;
                end
                ST_RS_SCL_REL: begin
                    if (scl_in) begin
                        state_d = ST_RS_SETUP; p_load = 1'b1; p_val = cfg_t_su_sta;
                    end else s_dec = 1'b1;
                end
                ST_RS_SETUP: begin
                    if (p_zero) begin
                        state_d = ST_STA_HOLD; p_load = 1'b1; p_val = cfg_t_hd_sta;
                    end else p_dec = 1'b1;
                end
                ST_SP_SCL_REL: begin
                    if (scl_in) begin
                        state_d = ST_SP_SETUP; p_load = 1'b1; p_val = cfg_t_su_sto;
                    end else s_dec = 1'b1;
                end
                ST_SP_SETUP: begin
                    if (p_zero) begin
                        state_d = ST_SP_BUF; p_load = 1'b1; p_val = cfg_t_buf;
                    end else p_dec = 1'b1;
                end
                ST_SP_BUF: begin
                    if (p_zero) begin
                        state_d = ST_IDLE; owned_d = 1'b0; done_d = 1'b1;
                    end else p_dec = 1'b1;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            owned_q  <= 1'b0;
            str_en_q <= 1'b0;
            done_q   <= 1'b0;
            arb_q    <= 1'b0;
            sto_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            owned_q  <= owned_d;
            str_en_q <= str_en_d;
            done_q   <= done_d;
            arb_q    <= arb_d;
            sto_q    <= sto_d;
            err_q    <= err_d;
        end
    end

    assign cmd_ready  = (state_q == ST_IDLE);
    assign owned      = owned_q;
    assign done       = done_q;
    assign arb_lost   = arb_q;
    assign stretch_to = sto_q;
    assign cmd_err    = err_q;

endmodule

// File: tb/tb_i2c_condition_generator.sv
// Bench for i2c_condition_generator: vector table, directed corner sequences and random commands vs a phase-length model.
module tb_i2c_condition_generator;
    import i2c_cond_pkg::*;

    localparam int W = 16;
    localparam logic [3:0] K_DONE = 4'b1000;
    localparam logic [3:0] K_ARB  = 4'b0100;
    localparam logic [3:0] K_TO   = 4'b0010;
    localparam logic [3:0] K_ERR  = 4'b0001;
    localparam int NV = 17;

    logic clk = 1'b0;
    logic reset;
    logic cmd_valid;
    logic [1:0] cmd_op;
    logic cmd_ready;
    logic [W-1:0] cfg_t_buf, cfg_t_hd_sta, cfg_t_su_sta, cfg_t_su_sto, cfg_t_stretch;
    logic scl_in, sda_in, scl_oe, sda_oe, owned, done, arb_lost, stretch_to, cmd_err;

    int stretch_left = 0;
    bit sda_force = 1'b0;
    int n_vec = 0;
    int n_miss = 0;

    // Open-drain bus: a slave may stretch SCL, a rival master may pull SDA.
    assign scl_in = ~scl_oe & (stretch_left == 0);
    assign sda_in = ~sda_oe & ~sda_force;

    always #5 clk = ~clk;

    i2c_condition_generator #(.CNT_W(W)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_ready(cmd_ready),
        .cfg_t_buf(cfg_t_buf), .cfg_t_hd_sta(cfg_t_hd_sta), .cfg_t_su_sta(cfg_t_su_sta),
        .cfg_t_su_sto(cfg_t_su_sto), .cfg_t_stretch(cfg_t_stretch),
        .scl_in(scl_in), .sda_in(sda_in), .scl_oe(scl_oe), .sda_oe(sda_oe), .owned(owned),
        .done(done), .arb_lost(arb_lost), .stretch_to(stretch_to), .cmd_err(cmd_err)
    );

    typedef struct {
        op_e        op;
        int         t_buf, t_hd, t_ss, t_sp, t_str, k;
        bit         arb;
        logic [3:0] kind;
        int         n;
        bit         own;
    } vec_t;

    vec_t tbl [NV];

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One clock; the slave consumes one stretch cycle for each cycle SCL was released by us.
    task automatic step();
        bit dec;
        dec = !scl_oe && (stretch_left > 0);
        @(posedge clk);
        #1;
        if (dec) stretch_left = stretch_left - 1;
    endtask

    task automatic set_cfg(input int b, input int h, input int ss, input int sp, input int st);
        cfg_t_buf     = W'(b);
        cfg_t_hd_sta  = W'(h);
        cfg_t_su_sta  = W'(ss);
        cfg_t_su_sto  = W'(sp);
        cfg_t_stretch = W'(st);
    endtask

    // Outcome from phase lengths: each timed phase is cfg+1 cycles, a stretch wait is k+1 cycles.
    function automatic void model(input op_e op, input bit own, input int tbf, input int hd,
                                  input int ss, input int sp, input int st, input int k,
                                  input bit arb, output logic [3:0] kind, output int n,
                                  output bit own_o);
        int t;
        own_o = own;
        kind  = K_ERR;
        n     = 0;
        if (op == OP_START && !own) begin
            kind = K_DONE; n = tbf + hd + 2; own_o = 1'b1;
        end else if ((op == OP_RESTART || op == OP_STOP) && own) begin
            t = hd + 1;
            if (st != 0 && k >= st) begin
                kind = K_TO; n = t + st; own_o = 1'b0;
            end else begin
                t = t + k + 1;
                if (op == OP_STOP) t = t + sp + 1;
                if (arb) begin
                    kind = K_ARB; n = t + 1; own_o = 1'b0;
                end else if (op == OP_RESTART) begin
                    kind = K_DONE; n = t + ss + 1 + hd + 1;
                end else begin
                    kind = K_DONE; n = t + tbf + 1; own_o = 1'b0;
                end
            end
        end
    endfunction

    task automatic run_and_check(input string name, input op_e op, input int k, input bit arb,
                                 input logic [3:0] exp_kind, input int exp_n, input bit exp_own,
                                 input int exp_rise);
        logic [3:0] kind;
        int n, rise;
        stretch_left = k;
        sda_force    = arb;
        cmd_op       = op;
        cmd_valid    = 1'b1;
        step();
        cmd_valid = 1'b0;
        kind = 4'b0;
        n    = -1;
        rise = -1;
        for (int i = 0; i < 300; i++) begin
            if (rise < 0 && sda_oe) rise = i;
            if ({done, arb_lost, stretch_to, cmd_err} != 4'b0) begin
                kind = {done, arb_lost, stretch_to, cmd_err};
                n    = i;
                break;
            end
            step();
        end
        chk({name, " kind"}, int'(kind), int'(exp_kind));
        chk({name, " latency"}, n, exp_n);
        chk({name, " owned"}, int'(owned), int'(exp_own));
        chk({name, " scl_oe"}, int'(scl_oe), int'(exp_own));
        chk({name, " sda_oe"}, int'(sda_oe), int'(exp_own));
        chk({name, " cmd_ready"}, int'(cmd_ready), 1);
        if (exp_rise >= 0) chk({name, " sda_rise"}, rise, exp_rise);
        step();
        chk({name, " pulse_width"}, int'({done, arb_lost, stretch_to, cmd_err}), 0);
        stretch_left = 0;
        sda_force    = 1'b0;
    endtask

    initial begin
        logic [3:0] m_kind;
        int m_n, seen, rb, rh, rss, rsp, rst, rk;
        bit own_m, m_own, rarb;
        op_e rop;

        tbl[0]  = '{OP_START,   4, 3, 2, 2, 0,   0, 1'b0, K_DONE,  9, 1'b1};
        tbl[1]  = '{OP_STOP,    2, 2, 2, 2, 0,   6, 1'b0, K_DONE, 16, 1'b0};
        tbl[2]  = '{OP_STOP,    0, 0, 0, 0, 0,   0, 1'b0, K_ERR,   0, 1'b0};
        tbl[3]  = '{OP_RESTART, 0, 0, 0, 0, 0,   0, 1'b0, K_ERR,   0, 1'b0};
        tbl[4]  = '{OP_RSVD,    0, 0, 0, 0, 0,   0, 1'b0, K_ERR,   0, 1'b0};
        tbl[5]  = '{OP_START,   0, 0, 0, 0, 0,   0, 1'b0, K_DONE,  2, 1'b1};
        tbl[6]  = '{OP_START,   0, 0, 0, 0, 0,   0, 1'b0, K_ERR,   0, 1'b1};
        tbl[7]  = '{OP_RSVD,    0, 0, 0, 0, 0,   0, 1'b0, K_ERR,   0, 1'b1};
        tbl[8]  = '{OP_RESTART, 1, 1, 1, 1, 0,   2, 1'b0, K_DONE,  9, 1'b1};
        tbl[9]  = '{OP_RESTART, 1, 1, 1, 1, 5,   3, 1'b0, K_DONE, 10, 1'b1};
        tbl[10] = '{OP_RESTART, 2, 2, 2, 2, 0,   0, 1'b1, K_ARB,   5, 1'b0};
        tbl[11] = '{OP_START,   3, 1, 1, 1, 0,   0, 1'b0, K_DONE,  6, 1'b1};
        tbl[12] = '{OP_STOP,    2, 2, 2, 2, 5, 100, 1'b0, K_TO,    8, 1'b0};
        tbl[13] = '{OP_START,   0, 0, 0, 0, 0,   0, 1'b0, K_DONE,  2, 1'b1};
        tbl[14] = '{OP_STOP,    1, 1, 1, 1, 0,   0, 1'b1, K_ARB,   6, 1'b0};
        tbl[15] = '{OP_START,   1, 0, 0, 0, 0,   0, 1'b0, K_DONE,  3, 1'b1};
        tbl[16] = '{OP_STOP,    1, 1, 1, 1, 0,   0, 1'b0, K_DONE,  7, 1'b0};

        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        set_cfg(0, 0, 0, 0, 0);
        #1;
        chk("reset scl_oe", int'(scl_oe), 0);
        chk("reset sda_oe", int'(sda_oe), 0);
        chk("reset owned", int'(owned), 0);
        chk("reset cmd_ready", int'(cmd_ready), 1);
        chk("reset pulses", int'({done, arb_lost, stretch_to, cmd_err}), 0);
        step();
        step();
        reset = 1'b0;
        step();

        for (int i = 0; i < NV; i++) begin
            set_cfg(tbl[i].t_buf, tbl[i].t_hd, tbl[i].t_ss, tbl[i].t_sp, tbl[i].t_str);
            run_and_check($sformatf("vec%0d", i), tbl[i].op, tbl[i].k, tbl[i].arb, tbl[i].kind,
                          tbl[i].n, tbl[i].own,
                          (tbl[i].op == OP_START && tbl[i].kind == K_DONE) ? tbl[i].t_buf + 1 : -1);
        end

        // Busy bus: SDA held low for 10 BUS_FREE cycles restarts tBUF from release.
        set_cfg(3, 2, 0, 0, 0);
        sda_force = 1'b1;
        cmd_op    = OP_START;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        repeat (9) step();
        chk("busfree held sda_oe", int'(sda_oe), 0);
        step();
        sda_force = 1'b0;
        repeat (3) step();
        chk("busfree before tbuf", int'(sda_oe), 0);
        step();
        chk("busfree sda_rise", int'(sda_oe), 1);
        repeat (3) step();
        chk("busfree done", int'(done), 1);
        chk("busfree owned", int'(owned), 1);
        step();
        chk("busfree done_width", int'(done), 0);

        set_cfg(0, 0, 0, 0, 0);
        run_and_check("stop_cfg0", OP_STOP, 0, 1'b0, K_DONE, 4, 1'b0, -1);

        // Reset in the middle of STA_HOLD must release both lines immediately.
        set_cfg(2, 5, 0, 0, 0);
        cmd_op    = OP_START;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        repeat (4) step();
        chk("sta_hold sda_oe", int'(sda_oe), 1);
        chk("sta_hold scl_oe", int'(scl_oe), 0);
        reset = 1'b1;
        #1;
        chk("midreset sda_oe", int'(sda_oe), 0);
        chk("midreset scl_oe", int'(scl_oe), 0);
        chk("midreset cmd_ready", int'(cmd_ready), 1);
        chk("midreset owned", int'(owned), 0);
        step();
        reset = 1'b0;
        seen = 0;
        repeat (10) begin
            step();
            if (done) seen++;
        end
        chk("midreset no_done", seen, 0);

        own_m = 1'b0;
        for (int it = 0; it < 40; it++) begin
            if (it % 5 == 4) rop = op_e'($urandom_range(0, 3));
            else if (own_m)  rop = op_e'($urandom_range(1, 2));
            else             rop = OP_START;
            rb   = $urandom_range(0, 4);
            rh   = $urandom_range(0, 4);
            rss  = $urandom_range(0, 4);
            rsp  = $urandom_range(0, 4);
            rst  = $urandom_range(0, 4);
            rk   = (rop == OP_START) ? 0 : $urandom_range(0, 5);
            rarb = (rop != OP_START) && ($urandom_range(0, 3) == 0);
            set_cfg(rb, rh, rss, rsp, rst);
            model(rop, own_m, rb, rh, rss, rsp, rst, rk, rarb, m_kind, m_n, m_own);
            run_and_check($sformatf("rnd%0d", it), rop, rk, rarb, m_kind, m_n, m_own,
                          (rop == OP_START && !own_m) ? rb + 1 : -1);
            own_m = m_own;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
